// File: rtl/qvalue_update_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qvalue_update_pkg
// Description : Shared widths, reward_data field offsets, FSM encoding and
//               saturation limits for the reward and Q-update stages.
// Revision    : 1.0 - initial release
// ============================================================================
package qvalue_update_pkg;

  localparam int WORD_WIDTH  = 16;
  localparam int FIELD_WIDTH = 16;
  localparam int RD_WIDTH    = 80;

  // reward_data layout: {action, besthop, reward, q_addr, max_next_q}
  localparam int ACTION_LSB     = 64;
  localparam int BESTHOP_LSB    = 48;
  localparam int REWARD_LSB     = 32;
  localparam int Q_ADDR_LSB     = 16;
  localparam int MAX_NEXT_Q_LSB = 0;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_CAPTURE = 3'd1;
  localparam state_t S_READ    = 3'd2;
  localparam state_t S_WAIT    = 3'd3;
  localparam state_t S_COMPUTE = 3'd4;
  localparam state_t S_WRITE   = 3'd5;
  localparam state_t S_DONE    = 3'd6;

  typedef struct packed {
    logic [FIELD_WIDTH-1:0] action;
    logic [FIELD_WIDTH-1:0] besthop;
    logic [FIELD_WIDTH-1:0] reward;
    logic [FIELD_WIDTH-1:0] q_addr;
    logic [FIELD_WIDTH-1:0] max_next_q;
  } reward_fields_t;

  function automatic reward_fields_t unpack_reward(input logic [RD_WIDTH-1:0] data);
    reward_fields_t f;
    f.action     = data[ACTION_LSB     +: FIELD_WIDTH];
    f.besthop    = data[BESTHOP_LSB    +: FIELD_WIDTH];
    f.reward     = data[REWARD_LSB     +: FIELD_WIDTH];
    f.q_addr     = data[Q_ADDR_LSB     +: FIELD_WIDTH];
    f.max_next_q = data[MAX_NEXT_Q_LSB +: FIELD_WIDTH];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qvalue_update_q_arith.sv
`default_nettype none
// ============================================================================
// Module      : q_arith
// Description : Combinational Q-learning update with floor shifts and
//               signed saturation of the result.
// Revision    : 1.0 - initial release
// ============================================================================
module q_arith #(
  parameter int WORD_WIDTH  = qvalue_update_pkg::WORD_WIDTH,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 1
) (
  input  logic [WORD_WIDTH-1:0] reward,
  input  logic [WORD_WIDTH-1:0] max_next_q,
  input  logic [WORD_WIDTH-1:0] q_old,
  output logic [WORD_WIDTH-1:0] q_result
);
  import qvalue_update_pkg::*;

  // Four guard bits cover the worst-case target and delta magnitudes.
  localparam int ARITH_WIDTH = WORD_WIDTH + 4;
  localparam int EXT_WIDTH   = ARITH_WIDTH - WORD_WIDTH;
  localparam logic signed [ARITH_WIDTH-1:0] SAT_HI = ARITH_WIDTH'(SAT_MAX);
  localparam logic signed [ARITH_WIDTH-1:0] SAT_LO = ARITH_WIDTH'(SAT_MIN);

  logic signed [ARITH_WIDTH-1:0] w_reward;
  logic signed [ARITH_WIDTH-1:0] w_max_next_q;
  logic signed [ARITH_WIDTH-1:0] w_q_old;
  logic signed [ARITH_WIDTH-1:0] w_target;
  logic signed [ARITH_WIDTH-1:0] w_delta;
  logic signed [ARITH_WIDTH-1:0] w_sum;

  assign w_reward     = {{EXT_WIDTH{reward[WORD_WIDTH-1]}}, reward};
  assign w_max_next_q = {{EXT_WIDTH{max_next_q[WORD_WIDTH-1]}}, max_next_q};
  assign w_q_old      = {{EXT_WIDTH{q_old[WORD_WIDTH-1]}}, q_old};

  assign w_target = w_reward + (w_max_next_q >>> GAMMA_SHIFT);
  assign w_delta  = w_target - w_q_old;
  assign w_sum    = w_q_old + (w_delta >>> ALPHA_SHIFT);

  always_comb begin
    q_result = w_sum[WORD_WIDTH-1:0];
    if (w_sum > SAT_HI) begin
      q_result = SAT_HI[WORD_WIDTH-1:0];
    end else if (w_sum < SAT_LO) begin
      q_result = SAT_LO[WORD_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/qvalue_update.sv
`default_nettype none
// ============================================================================
// Module      : qvalue_update
// Description : Read-modify-write of one Q-table entry per reward strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module qvalue_update #(
  parameter int WORD_WIDTH  = qvalue_update_pkg::WORD_WIDTH,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [79:0]           reward_data,
  input  logic                  done_reward,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] mem_data_in,
  input  logic [WORD_WIDTH-1:0] mem_data_out,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] q_new,
  output logic                  done_update
);
  import qvalue_update_pkg::*;

  state_t                r_state;
  state_t                w_next_state;
  reward_fields_t        r_fields;
  logic [WORD_WIDTH-1:0] r_q_old;
  logic [WORD_WIDTH-1:0] r_q_new;
  logic [WORD_WIDTH-1:0] w_q_result;
  logic                  r_done_update;
  logic                  w_unused_fields;

  assign w_unused_fields = ^{r_fields.action, r_fields.besthop};

  q_arith #(
    .WORD_WIDTH  (WORD_WIDTH),
    .ALPHA_SHIFT (ALPHA_SHIFT),
    .GAMMA_SHIFT (GAMMA_SHIFT)
  ) u_q_arith (
    .reward     (WORD_WIDTH'(r_fields.reward)),
    .max_next_q (WORD_WIDTH'(r_fields.max_next_q)),
    .q_old      (r_q_old),
    .q_result   (w_q_result)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:    w_next_state = done_reward ? S_CAPTURE : S_IDLE;
      S_CAPTURE: w_next_state = S_READ;
      S_READ:    w_next_state = S_WAIT;
      S_WAIT:    w_next_state = S_COMPUTE;
      S_COMPUTE: w_next_state = S_WRITE;
      S_WRITE:   w_next_state = S_DONE;
      // Waiting for the strobe to drop makes a held start count only once.
      S_DONE:    w_next_state = done_reward ? S_DONE : S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fields      <= '0;
      r_q_old       <= '0;
      r_q_new       <= '0;
      r_done_update <= 1'b0;
    end else begin
      if (r_state == S_CAPTURE) begin
        r_fields <= unpack_reward(reward_data);
      end
      if (r_state == S_WAIT) begin
        r_q_old <= mem_data_out;
      end
      if (r_state == S_COMPUTE) begin
        r_q_new <= w_q_result;
      end
      r_done_update <= (r_state == S_DONE);
    end
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    address     = '0;
    wr_en       = 1'b0;
    mem_data_in = '0;
    case (r_state)
      S_READ: begin
        address = WORD_WIDTH'(r_fields.q_addr);
      end
      S_WRITE: begin
        address     = WORD_WIDTH'(r_fields.q_addr);
        mem_data_in = r_q_new;
        // A reset landing on the write cycle must not commit the store.
        wr_en       = ~reset;
      end
      default: begin
        address = '0;
      end
    endcase
  end

  assign q_new       = r_q_new;
  assign done_update = r_done_update;

endmodule
`default_nettype wire

// File: tb/tb_qvalue_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_qvalue_update
// Description : Directed self-checking bench for qvalue_update.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qvalue_update;

  logic        clock;
  logic        reset;
  logic [79:0] reward_data;
  logic        done_reward;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        busy;
  logic [15:0] q_new;
  logic        done_update;

  logic [15:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  int          wr_count;
  int          checks;
  int          errors;
  int          wr_before;

  qvalue_update dut (
    .clock        (clock),
    .reset        (reset),
    .reward_data  (reward_data),
    .done_reward  (done_reward),
    .address      (address),
    .wr_en        (wr_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .q_new        (q_new),
    .done_update  (done_update)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial wr_count = 0;

  // Synchronous memory: read data appears one cycle after the address.
  always @(posedge clock) begin
    mem_data_out <= mem[address[7:0]];
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (wr_en) begin
      mem[address[7:0]] <= mem_data_in;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic start(input logic [7:0] qa, input logic [15:0] rew, input logic [15:0] mnq);
    reward_data = {16'hA5A5, 16'h5A5A, rew, {8'h00, qa}, mnq};
    done_reward = 1'b1;
  endtask

  // Single-pulse update: strobe dropped on the write cycle.
  task automatic run_update(input string tag, input logic [7:0] qa, input logic [15:0] q_old,
                            input logic [15:0] rew, input logic [15:0] mnq,
                            input logic [15:0] exp);
    preload(qa, q_old);
    wr_before = wr_count;
    start(qa, rew, mnq);
    repeat (2) tick();
    reward_data = {80{1'b1}};
    repeat (3) tick();
    check1({tag, " wr_en"}, wr_en, 1'b1);
    check16({tag, " address"}, address, {8'h00, qa});
    check16({tag, " mem_data_in"}, mem_data_in, exp);
    done_reward = 1'b0;
    tick();
    check1({tag, " done_early"}, done_update, 1'b0);
    tick();
    check1({tag, " done_update"}, done_update, 1'b1);
    check16({tag, " q_new"}, q_new, exp);
    check16({tag, " mem"}, mem[qa], exp);
    check_int({tag, " wr_count"}, wr_count - wr_before, 1);
    tick();
    check1({tag, " busy_idle"}, busy, 1'b0);
    check1({tag, " done_cleared"}, done_update, 1'b0);
    check16({tag, " addr_idle"}, address, 16'h0000);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    done_reward = 1'b0;
    reward_data = '0;
    pre_en      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    repeat (3) tick();
    reset = 1'b0;

    check1("rst busy", busy, 1'b0);
    check1("rst wr_en", wr_en, 1'b0);
    check1("rst done_update", done_update, 1'b0);
    check16("rst address", address, 16'h0000);
    check16("rst mem_data_in", mem_data_in, 16'h0000);
    check16("rst q_new", q_new, 16'h0000);

    // Nominal with cycle-by-cycle memory port view.
    preload(8'h40, 16'd100);
    start(8'h40, 16'd20, 16'd60);
    tick();
    check1("nom busy_capture", busy, 1'b1);
    check16("nom addr_capture", address, 16'h0000);
    tick();
    check16("nom addr_read", address, 16'h0040);
    check1("nom wr_en_read", wr_en, 1'b0);
    done_reward = 1'b0;
    repeat (4) tick();
    check1("nom done_edge5", done_update, 1'b0);
    check16("nom mem", mem[8'h40], 16'd87);
    tick();
    check1("nom done_edge6", done_update, 1'b1);
    check16("nom q_new", q_new, 16'd87);
    tick();

    run_update("nom2", 8'h41, 16'd100, 16'd20, 16'd60, 16'd87);
    run_update("sat_pos", 8'h10, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_update("neg", 8'h11, 16'h0000, 16'hFFD8, 16'h0000, 16'hFFF6);
    run_update("sat_neg", 8'h12, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    run_update("floor", 8'h13, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF);
    run_update("odd_mnq", 8'h14, 16'd10, 16'h0000, 16'hFFFD, 16'd7);

    // Held start: one write only, done_update held while strobe stays high.
    preload(8'h20, 16'd0);
    wr_before = wr_count;
    start(8'h20, 16'd4, 16'd0);
    repeat (20) tick();
    check_int("hold wr_count", wr_count - wr_before, 1);
    check1("hold done_update", done_update, 1'b1);
    check1("hold busy", busy, 1'b1);
    check16("hold q_new", q_new, 16'd1);
    done_reward = 1'b0;
    repeat (2) tick();
    check1("hold done_drop", done_update, 1'b0);
    check1("hold busy_drop", busy, 1'b0);

    // Reset in WAIT aborts the update.
    preload(8'h30, 16'd200);
    wr_before = wr_count;
    start(8'h30, 16'd0, 16'd0);
    repeat (3) tick();
    reset       = 1'b1;
    done_reward = 1'b0;
    tick();
    check1("rwait busy", busy, 1'b0);
    check1("rwait wr_en", wr_en, 1'b0);
    check16("rwait address", address, 16'h0000);
    check16("rwait q_new", q_new, 16'h0000);
    check1("rwait done_update", done_update, 1'b0);
    reset = 1'b0;
    repeat (6) tick();
    check_int("rwait no_write", wr_count - wr_before, 0);
    check16("rwait mem", mem[8'h30], 16'd200);
    run_update("after_rst", 8'h30, 16'd200, 16'd0, 16'd0, 16'd150);

    // Reset coincident with the write cycle blocks the store.
    preload(8'h50, 16'd5);
    wr_before = wr_count;
    start(8'h50, 16'd100, 16'd0);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check1("rwrite wr_en", wr_en, 1'b0);
    done_reward = 1'b0;
    tick();
    reset = 1'b0;
    check_int("rwrite no_write", wr_count - wr_before, 0);
    check16("rwrite mem", mem[8'h50], 16'd5);
    check1("rwrite busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
